// File: rtl/rggen_rtl_pkg.sv
// Shared types and sizing helpers for the rggen APB requester.
package rggen_rtl_pkg;

    // 2'b01 is reserved and never produced.
    typedef enum logic [1:0] {
        RGGEN_APB_REQUESTER_OKAY        = 2'b00,
        RGGEN_APB_REQUESTER_SLAVE_ERROR = 2'b10,
        RGGEN_APB_REQUESTER_TIMEOUT     = 2'b11
    } rggen_apb_requester_status;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_SETUP,
        REQ_ACCESS,
        REQ_RESPONSE
    } rggen_apb_requester_state;

    localparam int RGGEN_APB_REQUESTER_TIMEOUT_CYCLES = 256;

    // A disabled watchdog (limit 0) still needs a legal one-bit counter.
    function automatic int rggen_timeout_counter_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

    localparam int RGGEN_APB_REQUESTER_COUNTER_WIDTH =
        rggen_timeout_counter_width(RGGEN_APB_REQUESTER_TIMEOUT_CYCLES);

endpackage

// File: rtl/rggen_apb_if.sv
// APB bus bundle shared by requesters (master) and register blocks (slave).
interface rggen_apb_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                     psel;
    logic                     penable;
    logic [ADDRESS_WIDTH-1:0] paddr;
    logic [2:0]               pprot;
    logic                     pwrite;
    logic [BUS_WIDTH/8-1:0]   pstrb;
    logic [BUS_WIDTH-1:0]     pwdata;
    logic                     pready;
    logic [BUS_WIDTH-1:0]     prdata;
    logic                     pslverr;

    modport master (
        output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/rggen_timeout_counter.sv
// Watchdog counter: flags expiry in the LIMIT-th enabled cycle since the last clear.
module rggen_timeout_counter
    import rggen_rtl_pkg::*;
#(
    parameter int LIMIT = 256,
    parameter int WIDTH = rggen_timeout_counter_width(LIMIT)
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (i_clear) begin
            count_next = '0;
        end else if (i_enable && (count_reg != WIDTH'(LIMIT))) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // count_reg holds the stalled cycles already seen, so the current one makes LIMIT.
    generate
        if (LIMIT == 0) begin : g_disabled
            assign o_expired = 1'b0;
        end else begin : g_enabled
            assign o_expired = i_enable && (count_reg == WIDTH'(LIMIT - 1));
        end
    endgenerate
endmodule

// File: rtl/rggen_apb_requester.sv
// APB initiator: one valid/ready command in, one APB transfer, one valid/ready response out.
module rggen_apb_requester
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = RGGEN_APB_REQUESTER_TIMEOUT_CYCLES
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    rggen_apb_if.master              apb_if,
    input  logic                     i_request_valid,
    output logic                     o_request_ready,
    input  logic                     i_request_write,
    input  logic [ADDRESS_WIDTH-1:0] i_request_address,
    input  logic [BUS_WIDTH-1:0]     i_request_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_request_strobe,
    output logic                     o_response_valid,
    input  logic                     i_response_ready,
    output logic [BUS_WIDTH-1:0]     o_response_read_data,
    output logic [1:0]               o_response_status
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK =
        ~ADDRESS_WIDTH'((2 ** ADDR_LSB) - 1);

    rggen_apb_requester_state  state_reg;
    rggen_apb_requester_state  state_next;
    logic                      write_reg;
    logic [ADDRESS_WIDTH-1:0]  address_reg;
    logic [BUS_WIDTH-1:0]      write_data_reg;
    logic [STRB_WIDTH-1:0]     strobe_reg;
    logic [BUS_WIDTH-1:0]      read_data_reg;
    logic [BUS_WIDTH-1:0]      read_data_next;
    rggen_apb_requester_status status_reg;
    rggen_apb_requester_status status_next;
    logic [STRB_WIDTH-1:0]     strobe_masked;
    logic                      load_command;
    logic                      load_response;
    logic                      busy;
    logic                      request_ready;
    logic                      response_valid;
    logic                      watchdog_clear;
    logic                      watchdog_enable;
    logic                      watchdog_expired;

    // Reads never carry byte enables onto the bus.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_strobe
            assign strobe_masked[gi] = i_request_write & i_request_strobe[gi];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        request_ready   = 1'b0;
        response_valid  = 1'b0;
        load_command    = 1'b0;
        load_response   = 1'b0;
        watchdog_clear  = 1'b0;
        watchdog_enable = 1'b0;
        read_data_next  = '0;
        status_next     = RGGEN_APB_REQUESTER_OKAY;
        case (state_reg)
            REQ_IDLE: begin
                request_ready = 1'b1;
                if (i_request_valid) begin
                    load_command = 1'b1;
                    state_next   = REQ_SETUP;
                end
            end
            REQ_SETUP: begin
                watchdog_clear = 1'b1;
                state_next     = REQ_ACCESS;
            end
            REQ_ACCESS: begin
                watchdog_enable = !apb_if.pready;
                // pready takes priority over a watchdog expiring in the same cycle.
                if (apb_if.pready) begin
                    load_response = 1'b1;
                    state_next    = REQ_RESPONSE;
                    if (apb_if.pslverr) begin
                        status_next = RGGEN_APB_REQUESTER_SLAVE_ERROR;
                    end else if (!write_reg) begin
                        read_data_next = apb_if.prdata;
                    end
                end else if (watchdog_expired) begin
                    load_response = 1'b1;
                    status_next   = RGGEN_APB_REQUESTER_TIMEOUT;
                    state_next    = REQ_RESPONSE;
                end
            end
            REQ_RESPONSE: begin
                response_valid = 1'b1;
                if (i_response_ready) begin
                    state_next = REQ_IDLE;
                end
            end
            default: state_next = REQ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= REQ_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_reg      <= 1'b0;
            address_reg    <= '0;
            write_data_reg <= '0;
            strobe_reg     <= '0;
            read_data_reg  <= '0;
            status_reg     <= RGGEN_APB_REQUESTER_OKAY;
        end else begin
            if (load_command) begin
                write_reg      <= i_request_write;
                address_reg    <= i_request_address & ADDRESS_MASK;
                write_data_reg <= i_request_write_data;
                strobe_reg     <= strobe_masked;
            end
            if (load_response) begin
                read_data_reg <= read_data_next;
                status_reg    <= status_next;
            end
        end
    end

    rggen_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (watchdog_clear),
        .i_enable  (watchdog_enable),
        .o_expired (watchdog_expired)
    );

    // Bus outputs derive from the state register so reset clears them without a clock.
    assign busy           = (state_reg == REQ_SETUP) || (state_reg == REQ_ACCESS);
    assign apb_if.psel    = busy;
    assign apb_if.penable = (state_reg == REQ_ACCESS);
    assign apb_if.paddr   = busy ? address_reg : '0;
    assign apb_if.pprot   = 3'b000;
    assign apb_if.pwrite  = busy & write_reg;
    assign apb_if.pstrb   = busy ? strobe_reg : '0;
    assign apb_if.pwdata  = busy ? write_data_reg : '0;

    assign o_request_ready      = request_ready;
    assign o_response_valid     = response_valid;
    assign o_response_read_data = read_data_reg;
    assign o_response_status    = status_reg;
endmodule

// File: tb/tb_rggen_apb_requester.sv
// Randomized bench for rggen_apb_requester against a transaction-level memory model.
module tb_rggen_apb_requester;
    localparam int AW = 16;
    localparam int BW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic          request_valid;
    logic          request_ready;
    logic          request_write;
    logic [AW-1:0] request_address;
    logic [BW-1:0] request_write_data;
    logic [3:0]    request_strobe;
    logic          response_valid;
    logic          response_ready;
    logic [BW-1:0] response_read_data;
    logic [1:0]    response_status;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem   [16];

    rggen_apb_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) apb_bus ();

    rggen_apb_requester #(
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .apb_if               (apb_bus),
        .i_request_valid      (request_valid),
        .o_request_ready      (request_ready),
        .i_request_write      (request_write),
        .i_request_address    (request_address),
        .i_request_write_data (request_write_data),
        .i_request_strobe     (request_strobe),
        .o_response_valid     (response_valid),
        .i_response_ready     (response_ready),
        .o_response_read_data (response_read_data),
        .o_response_status    (response_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_junk_request();
        request_valid      = 1'b1;
        request_write      = 1'($urandom_range(0, 1));
        request_address    = AW'($urandom);
        request_write_data = $urandom;
        request_strobe     = 4'($urandom);
    endtask

    // One command end to end. waits = stalled ACCESS cycles before pready.
    task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input bit err, input int resp_delay);
        logic [AW-1:0] exp_addr;
        logic [3:0]    exp_strb;
        logic [31:0]   exp_data;
        logic [1:0]    exp_status;
        int            exp_acc;
        int            acc;
        int            idx;
        bit            bus_ok;
        bit            done;
        bit            hold_ok;

        idx      = int'(addr[5:2]);
        exp_addr = addr & 16'hFFFC;
        exp_strb = wr ? strb : 4'h0;
        exp_data = '0;
        if (waits >= TO) begin
            exp_status = 2'b11;
            exp_acc    = TO;
        end else begin
            exp_acc = waits + 1;
            if (err) begin
                exp_status = 2'b10;
            end else begin
                exp_status = 2'b00;
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    exp_data = ref_mem[idx];
                end
            end
        end

        @(negedge clk);
        check_value("ready_idle", 64'(request_ready), 64'd1);
        request_valid      = 1'b1;
        request_write      = wr;
        request_address    = addr;
        request_write_data = wdata;
        request_strobe     = strb;
        response_ready     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_junk_request();
        check_value("setup_psel", 64'(apb_bus.psel), 64'd1);
        check_value("setup_penable", 64'(apb_bus.penable), 64'd0);
        bus_ok = (apb_bus.paddr === exp_addr) && (apb_bus.pwrite === wr) &&
                 (apb_bus.pstrb === exp_strb) && (apb_bus.pwdata === wdata) &&
                 (apb_bus.pprot === 3'b000);
        check_value("setup_bus", 64'(bus_ok), 64'd1);
        @(posedge clk);

        acc  = 0;
        done = 0;
        for (int guard = 0; guard < 20; guard++) begin
            @(negedge clk);
            if (!(apb_bus.psel && apb_bus.penable)) begin
                done = 1;
                break;
            end
            drive_junk_request();
            bus_ok = bus_ok && (apb_bus.paddr === exp_addr) && (apb_bus.pwrite === wr) &&
                     (apb_bus.pstrb === exp_strb) && (apb_bus.pwdata === wdata);
            acc++;
            if (acc - 1 == waits) begin
                apb_bus.pready  = 1'b1;
                apb_bus.pslverr = err;
                if (err) begin
                    apb_bus.prdata = 32'hFFFF_FFFF;
                end else begin
                    apb_bus.prdata = slave_mem[apb_bus.paddr[5:2]];
                    if (apb_bus.pwrite)
                        for (int b = 0; b < 4; b++)
                            if (apb_bus.pstrb[b])
                                slave_mem[apb_bus.paddr[5:2]][8*b +: 8] = apb_bus.pwdata[8*b +: 8];
                end
            end else begin
                apb_bus.pready  = 1'b0;
                apb_bus.pslverr = 1'($urandom_range(0, 1));
                apb_bus.prdata  = $urandom;
            end
            @(posedge clk);
        end
        if (!done) @(negedge clk);
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        apb_bus.prdata  = '0;

        check_value("access_cycles", 64'(acc), 64'(exp_acc));
        check_value("bus_stable", 64'(bus_ok), 64'd1);
        check_value("resp_valid", 64'(response_valid), 64'd1);
        check_value("resp_data", 64'(response_read_data), 64'(exp_data));
        check_value("resp_status", 64'(response_status), 64'(exp_status));
        check_value("resp_bus_idle", {61'd0, apb_bus.psel, apb_bus.penable, (apb_bus.paddr != '0)}, 64'd0);
        check_value("resp_req_ready", 64'(request_ready), 64'd0);

        hold_ok = 1;
        for (int d = 0; d < resp_delay; d++) begin
            drive_junk_request();
            @(negedge clk);
            hold_ok = hold_ok && response_valid && (response_read_data === exp_data) &&
                      (response_status === exp_status) && !request_ready && !apb_bus.psel;
        end
        if (resp_delay > 0) check_value("resp_hold", 64'(hold_ok), 64'd1);

        response_ready = 1'b1;
        request_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        response_ready = 1'b0;
        check_value("after_hs_valid", 64'(response_valid), 64'd0);
        check_value("after_hs_ready", 64'(request_ready), 64'd1);
        check_value("after_hs_psel", 64'(apb_bus.psel), 64'd0);

        txn_no++;
        $display("txn %0d: %s addr=0x%04h wdata=0x%08h strb=%b waits=%0d err=%0d -> status=%0d data=0x%08h",
                 txn_no, wr ? "WR" : "RD", addr, wdata, strb, waits, err, exp_status, exp_data);
    endtask

    initial begin
        rst_n              = 1'b0;
        request_valid      = 1'b0;
        request_write      = 1'b0;
        request_address    = '0;
        request_write_data = '0;
        request_strobe     = '0;
        response_ready     = 1'b0;
        apb_bus.pready     = 1'b0;
        apb_bus.prdata     = '0;
        apb_bus.pslverr    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        slave_mem[4] = 32'hA5A5_1234;
        ref_mem[4]   = 32'hA5A5_1234;

        repeat (2) @(negedge clk);
        check_value("rst_req_ready", 64'(request_ready), 64'd1);
        check_value("rst_resp_valid", 64'(response_valid), 64'd0);
        check_value("rst_resp_data", 64'(response_read_data), 64'd0);
        check_value("rst_resp_status", 64'(response_status), 64'd0);
        check_value("rst_bus", {61'd0, apb_bus.psel, apb_bus.penable, (apb_bus.paddr != '0)}, 64'd0);
        rst_n = 1'b1;

        do_txn(1'b0, 16'h0010, 32'h0, 4'hF, 0, 1'b0, 0);
        do_txn(1'b1, 16'h0007, 32'hDEAD_BEEF, 4'b0101, 3, 1'b0, 0);
        do_txn(1'b0, 16'h0004, 32'h0, 4'h0, 0, 1'b0, 0);
        do_txn(1'b0, 16'h0008, 32'h0, 4'h0, 1, 1'b1, 0);
        do_txn(1'b0, 16'h000C, 32'h0, 4'h0, 6, 1'b0, 0);
        do_txn(1'b0, 16'h0010, 32'h0, 4'h0, 0, 1'b0, 0);
        do_txn(1'b1, 16'h000C, 32'h1357_9BDF, 4'b1111, 2, 1'b0, 5);
        do_txn(1'b0, 16'h000C, 32'h0, 4'h0, 3, 1'b1, 2);

        // Reset in the middle of an ACCESS phase aborts without a response.
        @(negedge clk);
        request_valid   = 1'b1;
        request_write   = 1'b0;
        request_address = 16'h0020;
        @(posedge clk);
        @(negedge clk);
        request_valid = 1'b0;
        @(negedge clk);
        check_value("pre_rst_penable", 64'(apb_bus.penable), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_value("async_rst_psel", 64'(apb_bus.psel), 64'd0);
        check_value("async_rst_penable", 64'(apb_bus.penable), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_value("post_rst_ready", 64'(request_ready), 64'd1);
        check_value("post_rst_resp", 64'(response_valid), 64'd0);
        check_value("post_rst_psel", 64'(apb_bus.psel), 64'd0);

        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom,
                   4'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
